weight_bank: RTL and testbench
==============================

WEIGHT_BANK -- requirements
Module: weight_bank

Interface
REQ-001 Parameter CLASSES, default 10: number of output neurons, i.e. bytes per weight word.
REQ-002 Parameter DEPTH, default 256: number of weight words, addressed 0..DEPTH-1.
REQ-003 Parameter LR_SHIFT, default 0: arithmetic right-shift applied to each delta byte before accumulation.
REQ-004 Parameter SEED, default 8'hA5: initial state of the init LFSR.
REQ-005 clk  in  1: single clock, rising edge.
REQ-006 reset  in  1: synchronous, active-high.
REQ-007 init_req  in  1: pulse to start an initialisation sweep of all words.
REQ-008 weight_addr  in  8: word address for read and update.
REQ-009 update  in  1: when high, apply delta to the word at weight_addr.
REQ-010 delta  in  CLASSES x 8: signed Q3.5 weight change per class.
REQ-011 weights  out  CLASSES x 8: registered signed Q3.5 read data.
REQ-012 busy  out  1: high while an init sweep is in progress.
REQ-013 init_done  out  1: one-cycle pulse when the init sweep completes.
REQ-014 sat_flag  out  1: sticky; set when any accumulation saturates.
REQ-015 drop_flag  out  1: sticky; set when an update is dropped.

Function
REQ-016 The FSM SHALL have exactly two states: S_SERVE and S_INIT.
- S_SERVE -> S_INIT on init_req.
- S_INIT -> S_SERVE after the write to word DEPTH-1.
REQ-017 In S_INIT, an internal index SHALL sweep 0..DEPTH-1 at one word per cycle, so the sweep takes DEPTH cycles; busy is high for exactly those cycles.
REQ-018 Init values SHALL come from an 8-bit Galois LFSR (mask 8'hB8) loaded with SEED on entry to S_INIT.
- The LFSR steps once per byte, in address-major, class-ascending order.
- Each byte written is the LFSR state arithmetic-shifted right by 2.
- The first byte written, word 0 class 0, is 8'hE9.
REQ-019 init_done SHALL pulse for one cycle on the cycle after the final init write; busy is low in that cycle.
REQ-020 init_req SHALL be ignored while in S_INIT.
REQ-021 An update asserted during S_INIT SHALL be dropped and set drop_flag; the memory is unaffected.
REQ-022 Reads: weights at cycle t+1 SHALL equal mem[weight_addr(t)], including any write committed in cycle t (write-first forwarding). During S_INIT, weights SHALL be held.
REQ-023 Updates SHALL use a 2-stage read-modify-write pipeline.
- Stage 1 at cycle t: capture addr, delta and valid, and issue the read.
- Stage 2 at cycle t+1: compute the per-byte sum and commit it to mem at the t+1 edge.
REQ-024 Per byte, sum = sat8(w + (delta >>> LR_SHIFT)), using 9-bit signed intermediate arithmetic.
- sat8 clamps to 8'h7F or 8'h80.
- Any clamp sets sat_flag.
REQ-025 Back-to-back updates (one per cycle) SHALL be accepted with no stall. If stage 1 reads an address whose write is pending in stage 2, the pending sum is forwarded, so no update is lost.
REQ-026 Addresses >= DEPTH (when DEPTH < 256) SHALL read as zero, and updates to them are dropped with drop_flag set.
REQ-027 If init_req and update are asserted in the same cycle in S_SERVE, the update SHALL complete before the sweep begins. An update already in stage 2 always commits.
REQ-028 sat_flag and drop_flag SHALL clear only on reset or on entry to S_INIT.

Reset
REQ-029 While reset is high, the following SHALL hold:
- state = S_SERVE, weights = 0, busy = 0, init_done = 0, sat_flag = 0, drop_flag = 0.
- LFSR = SEED and pipeline valid bits = 0.
- Memory contents are unchanged.
REQ-030 Reset asserted mid-sweep SHALL abort the sweep without an init_done pulse; a pending stage-2 write is discarded.

Verification
REQ-031 Pulse init_req -> busy is high for DEPTH cycles, then init_done pulses once, and reading addr 0 gives class 0 = 8'hE9.
REQ-032 Set mem[3] class 0 to 8'h70, then update addr 3 with delta 8'h20 -> 8'h7F and sat_flag = 1. Set it to 8'h80, then update with delta 8'hF0 -> 8'h80.
REQ-033 Starting from 8'h10, issue 3 consecutive updates to addr 5 with delta 8'h01 each -> 8'h13 (forwarding check). Reading addr 5 on the cycle after the last commit -> 8'h13.
REQ-034 Set LR_SHIFT=2; starting from 8'h00, update with delta 8'hF8 -> 8'hFE.
REQ-035 Update during busy -> drop_flag = 1 and memory unchanged. Reset at sweep cycle 100 -> busy = 0 and no init_done pulse.

Source files
------------

// File: rtl/weight_bank.sv
// -----------------------------------------------------------------------------
// weight_bank
//   Weight memory for a small classifier. Each of DEPTH words holds CLASSES
//   signed Q3.5 bytes. A single-cycle-issue read-modify-write pipeline
//   accumulates saturating deltas. An LFSR-driven sweep initialises all words.
//
// Ports
//   clk, reset        : clock (rising edge) and synchronous active-high reset
//   init_req          : pulse to start an initialisation sweep
//   weight_addr [7:0] : word address for read and update
//   update            : apply delta to word weight_addr
//   delta             : CLASSES signed bytes added to the addressed word
//   weights           : registered read data (held while sweeping)
//   busy              : high while the sweep is writing words
//   init_done         : one-cycle pulse after the final sweep write
//   sat_flag          : sticky, some accumulation clamped
//   drop_flag         : sticky, some update was discarded
// -----------------------------------------------------------------------------
module weight_bank #(
  parameter int         CLASSES  = 10,
  parameter int         DEPTH    = 256,
  parameter int         LR_SHIFT = 0,
  parameter logic [7:0] SEED     = 8'hA5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 init_req,
  input  logic [7:0]           weight_addr,
  input  logic                 update,
  input  logic [CLASSES*8-1:0] delta,
  output logic [CLASSES*8-1:0] weights,
  output logic                 busy,
  output logic                 init_done,
  output logic                 sat_flag,
  output logic                 drop_flag
);

  localparam int W  = CLASSES * 8;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {S_SERVE, S_INIT} state_t;

  state_t          state_reg;
  logic            init_pend_reg;
  logic [AW-1:0]   idx_reg;
  logic [7:0]      lfsr_reg;
  logic            s1_valid_reg;
  logic [AW-1:0]   s1_addr_reg;
  logic [W-1:0]    s1_delta_reg;
  logic [W-1:0]    rd_reg;
  logic            busy_reg;
  logic            init_done_reg;
  logic            sat_reg;
  logic            drop_reg;

  logic [W-1:0]    mem [DEPTH];

  logic            addr_ok;
  logic [AW-1:0]   rd_addr;
  logic            upd_accept;
  logic            upd_drop;
  logic            enter_init;
  logic [7:0]      lfsr_walk;
  logic [W-1:0]    init_word;
  logic [W-1:0]    sum_word;
  logic [CLASSES-1:0] sat_bits;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [W-1:0]    wr_data;

  assign addr_ok = (32'(weight_addr) < 32'(DEPTH));
  assign rd_addr = weight_addr[AW-1:0];

  // An update issued together with init_req is still accepted; the sweep is
  // then deferred one cycle (init_pend_reg) so its stage-2 commit lands before
  // the first sweep write. Updates in that deferral cycle are dropped.
  assign upd_accept = (state_reg == S_SERVE) && !init_pend_reg && update && addr_ok;
  assign upd_drop   = update && !upd_accept;
  assign enter_init = (state_reg == S_SERVE) &&
                      (init_pend_reg || (init_req && !update));

  // Galois LFSR (mask B8) stepped once per byte, class-ascending; each byte
  // is the pre-step state arithmetic-shifted right by two.
  always_comb begin
    lfsr_walk = lfsr_reg;
    init_word = '0;
    for (int c = 0; c < CLASSES; c++) begin
      init_word[c*8 +: 8] = {{2{lfsr_walk[7]}}, lfsr_walk[7:2]};
      lfsr_walk = {1'b0, lfsr_walk[7:1]} ^ (lfsr_walk[0] ? 8'hB8 : 8'h00);
    end
  end

  // Stage 2: per-byte saturating add on 9-bit intermediates.
  genvar gi;
  generate
    for (gi = 0; gi < CLASSES; gi++) begin : g_sum
      logic        [7:0] w_b;
      logic signed [7:0] d_b;
      logic        [8:0] s9;
      assign w_b = rd_reg[gi*8 +: 8];
      assign d_b = $signed(s1_delta_reg[gi*8 +: 8]) >>> LR_SHIFT;
      assign s9  = {w_b[7], w_b} + {d_b[7], d_b};
      assign sat_bits[gi] = s9[8] ^ s9[7];
      assign sum_word[gi*8 +: 8] = sat_bits[gi] ? (s9[8] ? 8'h80 : 8'h7F) : s9[7:0];
    end
  endgenerate

  // Single write port: sweep and stage-2 commit never coincide because no
  // update is in flight when the sweep starts.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    if (state_reg == S_INIT) begin
      wr_en   = 1'b1;
      wr_addr = idx_reg;
      wr_data = init_word;
    end else if (s1_valid_reg) begin
      wr_en   = 1'b1;
      wr_addr = s1_addr_reg;
      wr_data = sum_word;
    end
  end

  // Reset suppresses the write so a pending commit is discarded.
  always_ff @(posedge clk) begin
    if (wr_en && !reset) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= S_SERVE;
      init_pend_reg <= 1'b0;
      idx_reg       <= '0;
      lfsr_reg      <= SEED;
      s1_valid_reg  <= 1'b0;
      s1_addr_reg   <= '0;
      s1_delta_reg  <= '0;
      rd_reg        <= '0;
      busy_reg      <= 1'b0;
      init_done_reg <= 1'b0;
      sat_reg       <= 1'b0;
      drop_reg      <= 1'b0;
    end else begin
      s1_valid_reg <= upd_accept;
      if (upd_accept) begin
        s1_addr_reg  <= rd_addr;
        s1_delta_reg <= delta;
      end

      // Write-first read: a commit at this edge to the same word is returned,
      // which is also what forwards a pending sum into back-to-back updates.
      if (state_reg == S_SERVE) begin
        if (!addr_ok) begin
          rd_reg <= '0;
        end else if (wr_en && (wr_addr == rd_addr)) begin
          rd_reg <= wr_data;
        end else begin
          rd_reg <= mem[rd_addr];
        end
      end

      // Entering the sweep clears the flags; events in that same cycle win.
      sat_reg  <= (sat_reg && !enter_init) || (s1_valid_reg && (|sat_bits));
      drop_reg <= (drop_reg && !enter_init) || upd_drop;

      init_done_reg <= 1'b0;
      case (state_reg)
        S_SERVE: begin
          if (enter_init) begin
            state_reg     <= S_INIT;
            busy_reg      <= 1'b1;
            idx_reg       <= '0;
            lfsr_reg      <= SEED;
            init_pend_reg <= 1'b0;
          end else if (init_req && update) begin
            init_pend_reg <= 1'b1;
          end
        end
        S_INIT: begin
          idx_reg  <= idx_reg + 1'b1;
          lfsr_reg <= lfsr_walk;
          if (idx_reg == AW'(DEPTH - 1)) begin
            state_reg     <= S_SERVE;
            busy_reg      <= 1'b0;
            init_done_reg <= 1'b1;
          end
        end
        default: state_reg <= S_SERVE;
      endcase
    end
  end

  assign weights   = rd_reg;
  assign busy      = busy_reg;
  assign init_done = init_done_reg;
  assign sat_flag  = sat_reg;
  assign drop_flag = drop_reg;

endmodule

// File: tb/tb_weight_bank.sv
// -----------------------------------------------------------------------------
// tb_weight_bank
//   Drives two weight_bank instances from shared inputs: dut0 with default
//   parameters, dut1 with LR_SHIFT=2 and DEPTH=200 (exercises out-of-range
//   addresses). A behavioural byte-array model predicts read data and flags.
// -----------------------------------------------------------------------------
module tb_weight_bank;

  localparam int CL = 10;
  localparam int W  = CL * 8;
  localparam logic [7:0] SEED = 8'hA5;

  logic         clk = 1'b0;
  logic         reset, init_req, update;
  logic [7:0]   weight_addr;
  logic [W-1:0] delta;
  logic [W-1:0] weights0, weights1;
  logic         busy0, busy1, done0, done1, sat0, sat1, drop0, drop1;

  int checks   = 0;
  int failures = 0;

  logic [7:0] mm [2][256][CL];
  bit         m_sat [2];
  bit         m_drop [2];

  always #5 clk = ~clk;

  weight_bank #(.CLASSES(CL), .DEPTH(256), .LR_SHIFT(0), .SEED(SEED)) dut0 (
    .clk(clk), .reset(reset), .init_req(init_req), .weight_addr(weight_addr),
    .update(update), .delta(delta), .weights(weights0), .busy(busy0),
    .init_done(done0), .sat_flag(sat0), .drop_flag(drop0));

  weight_bank #(.CLASSES(CL), .DEPTH(200), .LR_SHIFT(2), .SEED(SEED)) dut1 (
    .clk(clk), .reset(reset), .init_req(init_req), .weight_addr(weight_addr),
    .update(update), .delta(delta), .weights(weights1), .busy(busy1),
    .init_done(done1), .sat_flag(sat1), .drop_flag(drop1));

  function automatic int depth_of(input int k);
    return (k == 0) ? 256 : 200;
  endfunction

  function automatic int shift_of(input int k);
    return (k == 0) ? 0 : 2;
  endfunction

  function automatic logic [W-1:0] model_word(input int k, input logic [7:0] a);
    logic [W-1:0] r;
    r = '0;
    if (int'(a) < depth_of(k))
      for (int c = 0; c < CL; c++) r[c*8 +: 8] = mm[k][a][c];
    return r;
  endfunction

  function automatic logic [W-1:0] b0(input logic [7:0] v);
    logic [W-1:0] r;
    r = '0;
    r[7:0] = v;
    return r;
  endfunction

  task automatic model_update(input logic [7:0] a, input logic [W-1:0] d);
    for (int k = 0; k < 2; k++) begin
      if (int'(a) >= depth_of(k)) begin
        m_drop[k] = 1'b1;
      end else begin
        for (int c = 0; c < CL; c++) begin
          int w, dv, s;
          w  = int'($signed(mm[k][a][c]));
          dv = int'($signed(d[c*8 +: 8])) >>> shift_of(k);
          s  = w + dv;
          if (s > 127) begin s = 127; m_sat[k] = 1'b1; end
          if (s < -128) begin s = -128; m_sat[k] = 1'b1; end
          mm[k][a][c] = 8'(s);
        end
      end
    end
  endtask

  task automatic model_init();
    for (int k = 0; k < 2; k++) begin
      logic [7:0] lf;
      lf = SEED;
      for (int a = 0; a < depth_of(k); a++)
        for (int c = 0; c < CL; c++) begin
          int v;
          v = int'($signed(lf)) >>> 2;
          mm[k][a][c] = 8'(v);
          lf = lf[0] ? ((lf >> 1) ^ 8'hB8) : (lf >> 1);
        end
    end
  endtask

  task automatic chk_w(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_v(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One serving cycle: read data after the edge must reflect every update
  // issued before this one.
  task automatic cycle(input bit upd, input logic [7:0] a, input logic [W-1:0] d,
                       input string tag);
    logic [W-1:0] e0, e1;
    update = upd; weight_addr = a; delta = d;
    e0 = model_word(0, a);
    e1 = model_word(1, a);
    step();
    chk_w({tag, "/w0"}, weights0, e0);
    chk_w({tag, "/w1"}, weights1, e1);
    if (upd) model_update(a, d);
    $display("txn %s upd=%0d addr=%0d w0=%h w1=%h", tag, upd, a, weights0, weights1);
    update = 1'b0;
  endtask

  task automatic chk_flags(input string tag);
    chk_v({tag, "/sat0"},  32'(sat0),  32'(m_sat[0]));
    chk_v({tag, "/sat1"},  32'(sat1),  32'(m_sat[1]));
    chk_v({tag, "/drop0"}, 32'(drop0), 32'(m_drop[0]));
    chk_v({tag, "/drop1"}, 32'(drop1), 32'(m_drop[1]));
  endtask

  // Sweep with optional update (upd_at) and ignored init_req (req_at) inside it.
  task automatic sweep(input int upd_at, input int req_at, input string tag);
    int nb0, nb1, nd0, nd1;
    bit fin;
    nb0 = 0; nb1 = 0; nd0 = 0; nd1 = 0; fin = 1'b0;
    init_req = 1'b1;
    step();
    init_req = 1'b0;
    m_sat[0] = 1'b0; m_sat[1] = 1'b0; m_drop[0] = 1'b0; m_drop[1] = 1'b0;
    for (int c = 0; c < 700 && !fin; c++) begin
      if (busy0) nb0++;
      if (busy1) nb1++;
      if (done0) begin nd0++; chk_v({tag, "/busy_at_done0"}, 32'(busy0), 32'd0); end
      if (done1) begin nd1++; chk_v({tag, "/busy_at_done1"}, 32'(busy1), 32'd0); end
      if (nd0 > 0 && nd1 > 0 && !busy0 && !busy1) begin
        fin = 1'b1;
      end else begin
        update = (c == upd_at); weight_addr = 8'd3; delta = {CL{8'h20}};
        init_req = (c == req_at);
        step();
        if (c == upd_at) begin m_drop[0] = 1'b1; m_drop[1] = 1'b1; end
      end
    end
    update = 1'b0; init_req = 1'b0;
    chk_v({tag, "/busy_cycles0"}, 32'(nb0), 32'd256);
    chk_v({tag, "/busy_cycles1"}, 32'(nb1), 32'd200);
    chk_v({tag, "/done_pulses0"}, 32'(nd0), 32'd1);
    chk_v({tag, "/done_pulses1"}, 32'(nd1), 32'd1);
    chk_flags(tag);
    model_init();
  endtask

  // Drive class 0 of word a (dut0) to target t: floor at 0x80, then add back.
  task automatic set0(input logic [7:0] a, input logic [7:0] t, input string tag);
    cycle(1'b1, a, b0(8'h80), tag);
    cycle(1'b1, a, b0(8'h80), tag);
    cycle(1'b1, a, b0(8'h7F), tag);
    cycle(1'b1, a, b0(t + 8'd1), tag);
    cycle(1'b0, a, '0, tag);
    chk_v({tag, "/target"}, 32'(weights0[7:0]), 32'(t));
  endtask

  initial begin
    reset = 1'b1; init_req = 1'b0; update = 1'b0; weight_addr = '0; delta = '0;
    repeat (3) step();
    chk_w("rst/w0", weights0, '0);
    chk_w("rst/w1", weights1, '0);
    chk_v("rst/busy", 32'({busy1, busy0}), 32'd0);
    chk_v("rst/done", 32'({done1, done0}), 32'd0);
    chk_v("rst/sat",  32'({sat1, sat0}),   32'd0);
    chk_v("rst/drop", 32'({drop1, drop0}), 32'd0);
    reset = 1'b0;
    step();

    // Initialisation sweep and first byte.
    sweep(-1, -1, "init1");
    cycle(1'b0, 8'd0, '0, "rd0");
    chk_v("e9/d0", 32'(weights0[7:0]), 32'hE9);
    chk_v("e9/d1", 32'(weights1[7:0]), 32'hE9);
    chk_v("done_once", 32'({done1, done0}), 32'd0);

    // Positive saturation with flag, after clearing flags via reset.
    set0(8'd3, 8'h70, "set70");
    reset = 1'b1; step(); reset = 1'b0;
    m_sat[0] = 1'b0; m_sat[1] = 1'b0; m_drop[0] = 1'b0; m_drop[1] = 1'b0;
    chk_v("sat_cleared", 32'({sat1, sat0}), 32'd0);
    cycle(1'b1, 8'd3, b0(8'h20), "sat_hi");
    cycle(1'b0, 8'd3, '0, "sat_hi");
    chk_v("sat_hi/val", 32'(weights0[7:0]), 32'h7F);
    chk_v("sat_hi/flag", 32'(sat0), 32'd1);
    chk_flags("sat_hi");

    // Negative saturation.
    set0(8'd3, 8'h80, "set80");
    cycle(1'b1, 8'd3, b0(8'hF0), "sat_lo");
    cycle(1'b0, 8'd3, '0, "sat_lo");
    chk_v("sat_lo/val", 32'(weights0[7:0]), 32'h80);
    chk_flags("sat_lo");

    // Back-to-back updates to one word.
    set0(8'd5, 8'h10, "set10");
    repeat (3) cycle(1'b1, 8'd5, b0(8'h01), "fwd");
    cycle(1'b0, 8'd5, '0, "fwd_rd");
    chk_v("fwd/val", 32'(weights0[7:0]), 32'h13);

    // Learning-rate shift on dut1: bring class 0 of word 9 to zero first.
    repeat (8) cycle(1'b1, 8'd9, b0(8'h80), "lr_floor");
    repeat (4) cycle(1'b1, 8'd9, b0(8'h7F), "lr_up");
    cycle(1'b1, 8'd9, b0(8'h10), "lr_up");
    cycle(1'b0, 8'd9, '0, "lr_zero");
    chk_v("lr/zero", 32'(weights1[7:0]), 32'h00);
    cycle(1'b1, 8'd9, b0(8'hF8), "lr_upd");
    cycle(1'b0, 8'd9, '0, "lr_rd");
    chk_v("lr/val", 32'(weights1[7:0]), 32'hFE);
    chk_flags("lr");

    // Random traffic, biased toward a few words to provoke forwarding.
    for (int i = 0; i < 320; i++) begin
      logic [7:0] a;
      logic [W-1:0] d;
      a = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 7));
      d = W'({$urandom(), $urandom(), $urandom()});
      cycle($urandom_range(0, 3) != 0, a, d, "rnd");
      if (i % 20 == 19) begin
        cycle(1'b0, a, '0, "rnd_idle");
        chk_flags("rnd");
      end
    end

    // Sweep with an update (dropped) and a repeated init_req (ignored).
    cycle(1'b0, 8'd0, '0, "pre_init2");
    sweep(10, 50, "init2");
    cycle(1'b0, 8'd3, '0, "post_drop");
    cycle(1'b0, 8'd199, '0, "post_last");

    // Reset in the middle of a sweep aborts it silently.
    init_req = 1'b1; step(); init_req = 1'b0;
    repeat (100) step();
    chk_v("abort/busy_before", 32'({busy1, busy0}), 32'd3);
    reset = 1'b1; step(); reset = 1'b0;
    chk_v("abort/busy_after", 32'({busy1, busy0}), 32'd0);
    begin
      int seen;
      seen = 0;
      for (int c = 0; c < 300; c++) begin
        if (done0 || done1 || busy0 || busy1) seen++;
        step();
      end
      chk_v("abort/no_done", 32'(seen), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
